fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one byte FIFO write port between NUM_REQ independent producers.
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst, terminated by req_last or MAX_BURST beats.
- It drives the FIFO's write strobe and data, and throttles on fifo_full.
- Sits directly in front of the 64x8 FIFO write side.

---
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that shares one FIFO write port between NUM_REQ
// producers. A producer is granted for a whole burst; the burst ends on a
// beat carrying req_last or after MAX_BURST beats, whichever comes first.
// One idle cycle separates consecutive bursts while the next winner is picked.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   req_valid    per-producer data valid
//   req_data     per-producer data, producer i at [i*DATA_W +: DATA_W]
//   req_last     per-producer end-of-burst marker (qualified by valid)
//   req_ready    per-producer accept, at most one bit set
//   fifo_full    FIFO full flag, throttles the granted producer
//   fifo_wr      FIFO write strobe, high on the same cycle as the handshake
//   fifo_in      FIFO write data, zero when no write is taking place
//   grant_valid  a burst grant is active
//   grant_id     index of the granted producer
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_in,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [6:0]      beat_cnt_q, beat_cnt_d;

    // Round-robin search result
    logic            found;
    logic [ID_W-1:0] next_id;
    int unsigned     cand;

    // Signals of the currently granted producer
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              beat;
    logic              burst_end;

    // Search starts just after the previous winner and wraps modulo NUM_REQ,
    // so the previous winner is considered last.
    always_comb begin
        found   = 1'b0;
        next_id = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                next_id = ID_W'(cand);
            end
        end
    end

    always_comb begin
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = req_data[32'(grant_id_q) * DATA_W +: DATA_W];
    end

    // A beat needs the grant, the producer's valid and room in the FIFO.
    // req_last only counts on a beat, so a stray last without valid is inert.
    always_comb begin
        beat      = (state_q == StBurst) && sel_valid && !fifo_full;
        burst_end = beat && (sel_last || (beat_cnt_q == 7'(MAX_BURST - 1)));
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_id_d = next_id;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                // Grant is held through full and through valid gaps; the
                // beat count survives both.
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 7'd1;
                end
                if (burst_end) begin
                    last_grant_d = grant_id_q;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        grant_valid = (state_q == StBurst);
        grant_id    = grant_id_q;
        req_ready   = '0;
        if ((state_q == StBurst) && !fifo_full) begin
            req_ready[grant_id_q] = 1'b1;
        end
        fifo_wr = beat;
        fifo_in = beat ? sel_data : '0;
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
